// File: rtl/dmem_stall_ctrl_if.sv
// ============================================================================
// Module      : dmem_stall_ctrl_if
// Description : Pipeline/data-memory bundle for the MEM-stage stall sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_stall_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Pipeline side
    logic            EX_MEM_MemRead;
    logic            EX_MEM_MemWrite;
    logic [AW-1:0]   EX_MEM_ADDR;
    logic [DW-1:0]   EX_MEM_WDATA;
    logic [DW/8-1:0] EX_MEM_BE;
    logic            MEM_Stall;
    logic [DW-1:0]   MEM_RDATA;
    logic            MEM_Fault;

    // Memory side
    logic            D_REQ;
    logic            D_WE;
    logic [AW-1:0]   D_ADDR;
    logic [DW-1:0]   D_WDATA;
    logic [DW/8-1:0] D_BE;
    logic            D_ACK;
    logic [DW-1:0]   D_RDATA;

    modport master (
        input  EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_ADDR, EX_MEM_WDATA, EX_MEM_BE,
        input  D_ACK, D_RDATA,
        output D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
        output MEM_Stall, MEM_RDATA, MEM_Fault
    );

    modport slave (
        output EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_ADDR, EX_MEM_WDATA, EX_MEM_BE,
        output D_ACK, D_RDATA,
        input  D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
        input  MEM_Stall, MEM_RDATA, MEM_Fault
    );
endinterface

`default_nettype wire

// File: rtl/dmem_stall_ctrl.sv
// ============================================================================
// Module      : dmem_stall_ctrl
// Description : MEM-stage req/ack sequencer that stalls the pipeline while a
//               data-memory access is outstanding. Optional access timeout
//               enabled by defining MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_stall_ctrl #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    dmem_stall_ctrl_if.master   bus
);

    localparam logic [1:0]    S_IDLE       = 2'd0;
    localparam logic [1:0]    S_REQ        = 2'd1;
    localparam logic [1:0]    S_DONE       = 2'd2;
    localparam logic [DW-1:0] c_FAULT_DATA = DW'(32'hDEADBEEF);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dmem_stall_ctrl: TIMEOUT_CYCLES must be at least 1");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("dmem_stall_ctrl: DW must be a multiple of 8");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_req;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_be;
    logic [DW-1:0]   r_rdata;
    logic            w_op;
    logic            w_start;
    logic            w_timeout;
    logic            w_fault;

    assign w_op    = bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite;
    assign w_start = (r_state == S_IDLE) & w_op;

`ifdef MEM_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fault;

    // An ack in the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_REQ) & ~bus.D_ACK &
                       (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_fault   = r_fault;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (r_state == S_REQ) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_fault   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_op) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.D_ACK || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request side and load-data capture; D_* stay frozen outside IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= bus.EX_MEM_MemWrite;
                r_addr  <= bus.EX_MEM_ADDR;
                r_wdata <= bus.EX_MEM_WDATA;
                r_be    <= bus.EX_MEM_BE;
            end else if (r_state == S_REQ) begin
                if (bus.D_ACK) begin
                    r_req <= 1'b0;
                    if (!r_we) begin
                        r_rdata <= bus.D_RDATA;
                    end
                end else if (w_timeout) begin
                    r_req   <= 1'b0;
                    r_rdata <= c_FAULT_DATA;
                end
            end
        end
    end

    assign bus.MEM_Stall = w_start | (r_state == S_REQ);
    assign bus.D_REQ     = r_req;
    assign bus.D_WE      = r_we;
    assign bus.D_ADDR    = r_addr;
    assign bus.D_WDATA   = r_wdata;
    assign bus.D_BE      = r_be;
    assign bus.MEM_RDATA = r_rdata;
    assign bus.MEM_Fault = w_fault;

endmodule

`default_nettype wire

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
MEM-stage sequencer between the pipeline and a variable-latency data memory with a req/ack handshake. It is the issuing end of the pipeline stall interface: it raises MEM_Stall to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding. It releases the stall for exactly one cycle when the access completes, presenting load data to MEM/WB.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables DW/8)
TIMEOUT_CYCLES, 64, max cycles waiting for D_ACK (used only with MEM_TIMEOUT_EN)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
EX_MEM_MemRead  input  1  load in MEM stage
EX_MEM_MemWrite  input  1  store in MEM stage
EX_MEM_ADDR  input  AW  access address
EX_MEM_WDATA  input  DW  store data
EX_MEM_BE  input  DW/8  byte enables
D_REQ  output  1  request to memory, held until ack
D_WE  output  1  1 = write
D_ADDR  output  AW  registered address
D_WDATA  output  DW  registered store data
D_BE  output  DW/8  registered byte enables
D_ACK  input  1  one-cycle completion pulse from memory
D_RDATA  input  DW  read data, valid with D_ACK
MEM_Stall  output  1  freeze upstream pipeline registers and PC
MEM_RDATA  output  DW  load data to MEM/WB
MEM_Fault  output  1  sticky timeout flag (MEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- States: IDLE, REQ, DONE. Reset → IDLE.
- Reset values: D_REQ=0, D_WE=0, D_ADDR=0, D_WDATA=0, D_BE=0, MEM_RDATA=0, MEM_Fault=0.
- MEM_Stall is combinational: (IDLE & (MemRead|MemWrite)) | REQ. It is 0 in DONE.
- IDLE with an op (cycle N):
  - Register addr, wdata and be.
  - D_WE = MemWrite. If MemRead and MemWrite are both high, write wins.
  - D_REQ=1 from cycle N+1. Next state REQ.
- REQ: hold D_REQ and all D_* stable.
  - D_ACK sampled high at cycle M: D_REQ=0 at M+1, next state DONE.
  - On a read, MEM_RDATA <= D_RDATA at the same edge.
  - On a write, MEM_RDATA holds its previous value.
- DONE: one cycle, stall low, pipeline advances, next state IDLE. The op still present during DONE is not reissued.
- Minimum access: ack in the first REQ cycle → stall for 2 cycles (N, N+1), DONE at N+2.
- D_ACK in IDLE or DONE is ignored. D_ACK is never a request.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE and stalls immediately. There is no overlap.
- RST mid-access: next edge → IDLE, D_REQ=0, pending access abandoned, MEM_RDATA=0. A late ack after reset is ignored.
- Non-memory instructions in IDLE: no stall, D_REQ stays 0, outputs hold.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle.
  - If the count reaches TIMEOUT_CYCLES without D_ACK, drop D_REQ, set MEM_RDATA to 32'hDEADBEEF (low DW bits), set sticky MEM_Fault=1 and go to DONE.
  - MEM_Fault clears only on RST.
  - An ack arriving in the same cycle as timeout wins: normal completion, no fault.
- Undefined: no counter, MEM_Fault tied 0, wait forever.

Test Plan:
- Load addr 0x100, memory acks in first REQ cycle with 0xCAFEF00D → D_REQ high 1 cycle, MEM_Stall high cycles N and N+1, low at N+2, MEM_RDATA=0xCAFEF00D.
- Store addr 0x200, wdata 0x12345678, BE=4'b0011, ack after 5 cycles → D_WE=1, D_* stable all 5 cycles, stall 6 cycles, MEM_RDATA unchanged.
- Two loads back-to-back, each acked after 2 cycles → two separate D_REQ bursts, exactly one DONE (stall-low) cycle between them, both data values captured in order.
- RST asserted on third REQ cycle, ack on the following cycle → D_REQ=0 after the reset edge, state IDLE, ack ignored, MEM_RDATA=0.
- Spurious D_ACK while IDLE with an ALU op in MEM → no stall, no D_REQ, MEM_RDATA unchanged.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack → D_REQ drops after 8 REQ cycles, MEM_RDATA=0xDEADBEEF, MEM_Fault=1 until RST.
